// File: rtl/alu1_pkg.sv
// Shared opcode definitions for the single-bit ALU slice.
package alu1_pkg;

    localparam int unsigned SEL_W = 3;

    typedef enum logic [SEL_W-1:0] {
        OP_AND      = 3'd0,
        OP_NOT      = 3'd1,
        OP_OR       = 3'd2,
        OP_XOR      = 3'd3,
        OP_ADD      = 3'd4,
        OP_SUB      = 3'd5,
        OP_TRANSFER = 3'd6,
        OP_TEST     = 3'd7
    } alu1_op_e;

    // Only the arithmetic ops drive carry_out; everything else forces it low.
    function automatic logic is_arith(input alu1_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_1bit_addsub.sv
// Combinational full adder / full subtractor; cout is the borrow when sub=1.
module alu_1bit_addsub (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sub,
    output logic sum,
    output logic cout
);

    logic w_carry;
    logic w_borrow;

    assign sum      = a ^ b ^ cin;
    assign w_carry  = (a & b) | (a & cin) | (b & cin);
    // Borrow is set whenever a < b + cin.
    assign w_borrow = (~a & (b | cin)) | (b & cin);
    assign cout     = sub ? w_borrow : w_carry;

endmodule

// File: rtl/alu_1bit.sv
// Single-bit ALU slice: opcode mux, carry gating and optional output register.
module alu_1bit
    import alu1_pkg::*;
#(
    parameter int unsigned REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             carry_in,
    input  logic [SEL_W-1:0] select,
    output logic             out,
    output logic             carry_out
);

    alu1_op_e w_op;
    logic     w_sum;
    logic     w_cout;
    logic     w_out;
    logic     w_carry;

    assign w_op = alu1_op_e'(select);

    alu_1bit_addsub u_addsub (
        .a    (a),
        .b    (b),
        .cin  (carry_in),
        .sub  (w_op == OP_SUB),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Result mux; carry_out is only meaningful for ADD/SUB.
    always_comb begin
        w_out   = 1'b0;
        w_carry = 1'b0;
        case (w_op)
            OP_AND:      w_out = a & b;
            OP_NOT:      w_out = ~a;
            OP_OR:       w_out = a | b;
            OP_XOR:      w_out = a ^ b;
            OP_ADD:      w_out = w_sum;
            OP_SUB:      w_out = w_sum;
            OP_TRANSFER: w_out = a;
            OP_TEST:     w_out = ~(a ^ b);
            default:     w_out = 1'b0;
        endcase
        if (is_arith(w_op)) begin
            w_carry = w_cout;
        end
    end

    if (REG_OUT != 0) begin : g_reg
        logic r_out;
        logic r_carry;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_out   <= 1'b0;
                r_carry <= 1'b0;
            end else begin
                r_out   <= w_out;
                r_carry <= w_carry;
            end
        end

        assign out       = r_out;
        assign carry_out = r_carry;
    end else begin : g_comb
        // Clock and reset have no role in the combinational build.
        logic w_unused;
        assign w_unused  = clk & rst_n;
        assign out       = w_out;
        assign carry_out = w_carry;
    end

endmodule

// File: tb/tb_alu_1bit.sv
// Directed bench for alu_1bit: registered and combinational builds side by side.
module tb_alu_1bit;

    logic       clk;
    logic       clk_static;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       carry_in;
    logic [2:0] select;
    logic       out_r;
    logic       cout_r;
    logic       out_c;
    logic       cout_c;

    int checks;
    int errors;

    alu_1bit #(.REG_OUT(1)) dut_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .select    (select),
        .out       (out_r),
        .carry_out (cout_r)
    );

    alu_1bit #(.REG_OUT(0)) dut_comb (
        .clk       (clk_static),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .select    (select),
        .out       (out_c),
        .carry_out (cout_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written truth tables; bit index = {a, b, carry_in}.
    function automatic logic [7:0] out_table(input int op);
        case (op)
            0:       return 8'b1100_0000;
            1:       return 8'b0000_1111;
            2:       return 8'b1111_1100;
            3:       return 8'b0011_1100;
            4:       return 8'b1001_0110;
            5:       return 8'b1001_0110;
            6:       return 8'b1111_0000;
            default: return 8'b1100_0011;
        endcase
    endfunction

    function automatic logic [7:0] cout_table(input int op);
        case (op)
            4:       return 8'b1110_1000;
            5:       return 8'b1000_1110;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic drive(input int op, input logic va, input logic vb, input logic vc);
        select   = 3'(op);
        a        = va;
        b        = vb;
        carry_in = vc;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(4, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (out_r !== 1'b0 || cout_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_state out=%b cout=%b expected 0 0", out_r, cout_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep_reg;
        logic [7:0] t_out;
        logic [7:0] t_cout;
        for (int op = 0; op < 8; op++) begin
            t_out  = out_table(op);
            t_cout = cout_table(op);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                drive(op, i[2], i[1], i[0]);
                @(posedge clk);
                #1;
                checks++;
                if (out_r !== t_out[i] || cout_r !== t_cout[i]) begin
                    errors++;
                    $display("FAIL sweep_reg op=%0d abc=%03b out=%b cout=%b expected %b %b",
                             op, 3'(i), out_r, cout_r, t_out[i], t_cout[i]);
                end
            end
        end
    endtask

    task automatic test_directed;
        // {op, a, b, cin, out, cout}
        logic [7:0] vec [14];
        vec = '{
            {3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1},
            {3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
            {3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
            {3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1},
            {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
            {3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
            {3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
            {3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
            {3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
            {3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
            {3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
            {3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
            {3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
            {3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}
        };
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            drive(int'(vec[k][7:5]), vec[k][4], vec[k][3], vec[k][2]);
            @(posedge clk);
            #1;
            checks++;
            if (out_r !== vec[k][1] || cout_r !== vec[k][0]) begin
                errors++;
                $display("FAIL directed_%0d out=%b cout=%b expected %b %b",
                         k, out_r, cout_r, vec[k][1], vec[k][0]);
            end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        drive(4, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (out_r !== 1'b1 || cout_r !== 1'b1) begin
            errors++;
            $display("FAIL rst_preload out=%b cout=%b expected 1 1", out_r, cout_r);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_r !== 1'b0 || cout_r !== 1'b0) begin
            errors++;
            $display("FAIL rst_async out=%b cout=%b expected 0 0", out_r, cout_r);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_r !== 1'b0 || cout_r !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold out=%b cout=%b expected 0 0", out_r, cout_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_r !== 1'b0 || cout_r !== 1'b0) begin
            errors++;
            $display("FAIL rst_release out=%b cout=%b expected 0 0", out_r, cout_r);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_r !== 1'b1 || cout_r !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_edge out=%b cout=%b expected 1 1", out_r, cout_r);
        end
    endtask

    task automatic test_latency;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (out_r !== 1'b0) begin
            errors++;
            $display("FAIL lat_and out=%b expected 0", out_r);
        end
        @(negedge clk);
        select = 3'd2;
        #1;
        checks++;
        if (out_r !== 1'b0) begin
            errors++;
            $display("FAIL lat_before_edge out=%b expected 0", out_r);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_r !== 1'b1 || cout_r !== 1'b0) begin
            errors++;
            $display("FAIL lat_after_edge out=%b cout=%b expected 1 0", out_r, cout_r);
        end
    endtask

    task automatic test_sweep_comb;
        logic [7:0] t_out;
        logic [7:0] t_cout;
        for (int op = 0; op < 8; op++) begin
            t_out  = out_table(op);
            t_cout = cout_table(op);
            for (int i = 0; i < 8; i++) begin
                drive(op, i[2], i[1], i[0]);
                #5;
                checks++;
                if (out_c !== t_out[i] || cout_c !== t_cout[i]) begin
                    errors++;
                    $display("FAIL sweep_comb op=%0d abc=%03b out=%b cout=%b expected %b %b",
                             op, 3'(i), out_c, cout_c, t_out[i], t_cout[i]);
                end
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        clk_static = 1'b0;
        rst_n      = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);
        test_reset;
        test_sweep_reg;
        test_directed;
        test_async_reset;
        test_latency;
        test_sweep_comb;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
